// File: rtl/ucsie_ltsm.sv
// Link training and status state machine: DETECT dwell, lane pattern resolution with width
// degrade, sideband config handshake, retry/fail accounting and retrain handling.
module ucsie_ltsm #(
    parameter int NUM_LANES  = 16,
    parameter int DETECT_CYC = 1000,
    parameter int TRAIN_CYC  = 5000,
    parameter int MAX_RETRY  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] lane_ok,
    input  logic                 lane_ok_valid,
    output logic                 sb_req,
    input  logic                 sb_ack,
    input  logic                 link_err,
    input  logic                 retrain_req,
    output logic [3:0]           state,
    output logic                 link_up,
    output logic [NUM_LANES-1:0] active_lanes,
    output logic [1:0]           width_code,
    output logic [7:0]           retrain_cnt,
    output logic                 train_fail
);

    typedef enum logic [3:0] {
        ST_RESET   = 4'd0,
        ST_DETECT  = 4'd1,
        ST_PATTERN = 4'd2,
        ST_CONFIG  = 4'd3,
        ST_ACTIVE  = 4'd4,
        ST_RETRAIN = 4'd5,
        ST_FAIL    = 4'd6
    } state_t;

    localparam int TMR_MAX = (DETECT_CYC > TRAIN_CYC) ? DETECT_CYC : TRAIN_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] DET_LAST = TMR_W'(DETECT_CYC - 1);
    localparam logic [TMR_W-1:0] TRN_LAST = TMR_W'(TRAIN_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    localparam logic [NUM_LANES-1:0] MASK_ALL = {NUM_LANES{1'b1}};
    localparam logic [NUM_LANES-1:0] MASK_LO  = MASK_ALL >> (NUM_LANES / 2);
    localparam logic [NUM_LANES-1:0] MASK_HI  = MASK_ALL << (NUM_LANES / 2);
    localparam logic [NUM_LANES-1:0] MASK_QTR = MASK_ALL >> (NUM_LANES - NUM_LANES / 4);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [TMR_W-1:0]       timer_r;
    logic [3:0]             attempt_r;
    logic [3:0]             attempt_inc_s;
    logic                   fail_s;
    logic                   resolve_s;
    logic                   match_s;
    logic [NUM_LANES-1:0]   mask_s;
    logic [1:0]             width_s;
    logic                   sb_req_r;
    logic                   link_up_r;
    logic [NUM_LANES-1:0]   active_lanes_r;
    logic [1:0]             width_code_r;
    logic [7:0]             retrain_cnt_r;
    logic                   train_fail_r;

    assign attempt_inc_s = attempt_r + 4'd1;

    // Lane resolution: widest contiguous passing group wins, in fixed priority order.
    always_comb begin
        match_s = 1'b0;
        mask_s  = '0;
        width_s = 2'd0;
        if ((lane_ok & MASK_ALL) == MASK_ALL) begin
            match_s = 1'b1;
            mask_s  = MASK_ALL;
            width_s = 2'd3;
        end else if ((lane_ok & MASK_LO) == MASK_LO) begin
            match_s = 1'b1;
            mask_s  = MASK_LO;
            width_s = 2'd2;
        end else if ((lane_ok & MASK_HI) == MASK_HI) begin
            match_s = 1'b1;
            mask_s  = MASK_HI;
            width_s = 2'd2;
        end else if ((lane_ok & MASK_QTR) == MASK_QTR) begin
            match_s = 1'b1;
            mask_s  = MASK_QTR;
            width_s = 2'd1;
        end else begin
            match_s = 1'b0;
        end
    end

    // Next-state logic; dropping start overrides everything, and event inputs beat timeouts.
    always_comb begin
        state_nxt_s = state_r;
        fail_s      = 1'b0;
        resolve_s   = 1'b0;
        if (!start) begin
            state_nxt_s = ST_RESET;
        end else begin
            case (state_r)
                ST_RESET:   state_nxt_s = ST_DETECT;
                ST_DETECT: begin
                    if (timer_r == DET_LAST) state_nxt_s = ST_PATTERN;
                    else                     state_nxt_s = ST_DETECT;
                end
                ST_PATTERN: begin
                    if (lane_ok_valid) begin
                        if (match_s) begin
                            resolve_s   = 1'b1;
                            state_nxt_s = ST_CONFIG;
                        end else begin
                            fail_s = 1'b1;
                        end
                    end else if (timer_r == TRN_LAST) begin
                        fail_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_PATTERN;
                    end
                end
                ST_CONFIG: begin
                    if (sb_ack)                   state_nxt_s = ST_ACTIVE;
                    else if (timer_r == TRN_LAST) fail_s = 1'b1;
                    else                          state_nxt_s = ST_CONFIG;
                end
                ST_ACTIVE: begin
                    if (link_err || retrain_req) state_nxt_s = ST_RETRAIN;
                    else                         state_nxt_s = ST_ACTIVE;
                end
                ST_RETRAIN: state_nxt_s = ST_DETECT;
                ST_FAIL:    state_nxt_s = ST_FAIL;
                default:    state_nxt_s = ST_RESET;
            endcase
            if (fail_s) begin
                state_nxt_s = (attempt_inc_s >= 4'(MAX_RETRY)) ? ST_FAIL : ST_DETECT;
            end else begin
                state_nxt_s = state_nxt_s;
            end
        end
    end

    // State, timer, attempt counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_RESET;
            timer_r        <= '0;
            attempt_r      <= 4'd0;
            sb_req_r       <= 1'b0;
            link_up_r      <= 1'b0;
            active_lanes_r <= '0;
            width_code_r   <= 2'd0;
            retrain_cnt_r  <= 8'd0;
            train_fail_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;

            if (state_nxt_s != state_r) begin
                timer_r <= '0;
            end else if (state_r == ST_DETECT || state_r == ST_PATTERN || state_r == ST_CONFIG) begin
                timer_r <= timer_r + TMR_ONE;
            end else begin
                timer_r <= '0;
            end

            if (state_r == ST_RESET || state_r == ST_RETRAIN) begin
                attempt_r <= 4'd0;
            end else if (fail_s) begin
                attempt_r <= attempt_inc_s;
            end else begin
                attempt_r <= attempt_r;
            end

            if (state_nxt_s == ST_RESET || fail_s) begin
                active_lanes_r <= '0;
                width_code_r   <= 2'd0;
            end else if (resolve_s) begin
                active_lanes_r <= mask_s;
                width_code_r   <= width_s;
            end else begin
                active_lanes_r <= active_lanes_r;
                width_code_r   <= width_code_r;
            end

            // Count on entry to RETRAIN so the new value is visible while the link is down.
            if (state_r == ST_ACTIVE && state_nxt_s == ST_RETRAIN && retrain_cnt_r != 8'hFF) begin
                retrain_cnt_r <= retrain_cnt_r + 8'd1;
            end else begin
                retrain_cnt_r <= retrain_cnt_r;
            end

            sb_req_r     <= (state_nxt_s == ST_CONFIG);
            link_up_r    <= (state_nxt_s == ST_ACTIVE);
            train_fail_r <= (state_nxt_s == ST_FAIL);
        end
    end

    assign state        = state_r;
    assign sb_req       = sb_req_r;
    assign link_up      = link_up_r;
    assign active_lanes = active_lanes_r;
    assign width_code   = width_code_r;
    assign retrain_cnt  = retrain_cnt_r;
    assign train_fail   = train_fail_r;

endmodule

// File: tb/tb_ucsie_ltsm.sv
// Self-checking bench for ucsie_ltsm: directed scenarios plus randomized lane patterns
// checked against a lane-counting reference model.
module tb_ucsie_ltsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] lane_ok = 16'h0000;
    logic        lane_ok_valid = 1'b0;
    logic        sb_req;
    logic        sb_ack = 1'b0;
    logic        link_err = 1'b0;
    logic        retrain_req = 1'b0;
    logic [3:0]  state;
    logic        link_up;
    logic [15:0] active_lanes;
    logic [1:0]  width_code;
    logic [7:0]  retrain_cnt;
    logic        train_fail;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int m_rc     = 0;

    ucsie_ltsm #(.NUM_LANES(16), .DETECT_CYC(8), .TRAIN_CYC(32), .MAX_RETRY(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lane_ok(lane_ok), .lane_ok_valid(lane_ok_valid),
        .sb_req(sb_req), .sb_ack(sb_ack), .link_err(link_err), .retrain_req(retrain_req),
        .state(state), .link_up(link_up), .active_lanes(active_lanes), .width_code(width_code),
        .retrain_cnt(retrain_cnt), .train_fail(train_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: count passing lanes per group and pick the widest qualifying group.
    function automatic void ref_resolve(input logic [15:0] v, output logic [15:0] m,
                                        output logic [1:0] w, output bit ok);
        int lo = 0, hi = 0, q = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                if (i < 8) lo++; else hi++;
                if (i < 4) q++;
            end
        end
        ok = 1'b1;
        if (lo + hi == 16)  begin m = 16'hFFFF; w = 2'd3; end
        else if (lo == 8)   begin m = 16'h00FF; w = 2'd2; end
        else if (hi == 8)   begin m = 16'hFF00; w = 2'd2; end
        else if (q == 4)    begin m = 16'h000F; w = 2'd1; end
        else begin m = 16'h0000; w = 2'd0; ok = 1'b0; end
    endfunction

    function automatic logic [15:0] rand_pat();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 4))
            0: return 16'hFFFF;
            1: return r | 16'h00FF;
            2: return r | 16'hFF00;
            3: return r | 16'h000F;
            default: return r;
        endcase
    endfunction

    task automatic test_reset();
        #2;
        chk_cnt++;
        if ({state, link_up, sb_req, width_code, train_fail} !== 9'd0) $display("FAIL reset_ctl: got %h want 0", {state, link_up, sb_req, width_code, train_fail});
        else pass_cnt++;
        chk_cnt++;
        if ({active_lanes, retrain_cnt} !== 24'd0) $display("FAIL reset_data: got %h want 0", {active_lanes, retrain_cnt});
        else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        step(2);
        chk_cnt++;
        if (state !== 4'd0) $display("FAIL idle_no_start: got %0d want 0", state);
        else pass_cnt++;
    endtask

    task automatic test_full_width();
        start = 1'b1;
        step(1);
        chk_cnt++;
        if (state !== 4'd1) $display("FAIL enter_detect: got %0d want 1", state);
        else pass_cnt++;
        step(7);
        chk_cnt++;
        if (state !== 4'd1) $display("FAIL detect_dwell: got %0d want 1", state);
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if (state !== 4'd2) $display("FAIL enter_pattern: got %0d want 2", state);
        else pass_cnt++;
        lane_ok = 16'hFFFF; lane_ok_valid = 1'b1;
        step(1);
        lane_ok_valid = 1'b0;
        chk_cnt++;
        if ({state, sb_req, active_lanes, width_code} !== {4'd3, 1'b1, 16'hFFFF, 2'd3})
            $display("FAIL full_config: got st=%0d req=%0d m=%h w=%0d want 3 1 ffff 3", state, sb_req, active_lanes, width_code);
        else pass_cnt++;
        step(1);
        sb_ack = 1'b1;
        step(1);
        sb_ack = 1'b0;
        chk_cnt++;
        if ({state, link_up, sb_req, active_lanes, width_code} !== {4'd4, 1'b1, 1'b0, 16'hFFFF, 2'd3})
            $display("FAIL full_active: got st=%0d up=%0d req=%0d m=%h w=%0d want 4 1 0 ffff 3", state, link_up, sb_req, active_lanes, width_code);
        else pass_cnt++;
    endtask

    task automatic test_degrade();
        logic [15:0] tbl [4];
        logic [15:0] v, em;
        logic [1:0]  ew;
        bit          eok, restart;
        int          attempts, exp_st;
        tbl = '{16'hF0FF, 16'hFFF0, 16'h000F, 16'h0F07};
        restart = 1'b1;
        attempts = 0;
        for (int t = 0; t < 28; t++) begin
            v = (t < 4) ? tbl[t] : rand_pat();
            if (restart) begin
                start = 1'b0; step(1);
                start = 1'b1; step(1);
                attempts = 0; restart = 1'b0;
            end
            for (int d = 0; d < 8; d++) begin
                lane_ok_valid = 1'($urandom_range(0, 1)); lane_ok = 16'hFFFF;
                sb_ack = 1'($urandom_range(0, 1)); link_err = 1'($urandom_range(0, 1));
                retrain_req = 1'($urandom_range(0, 1));
                step(1);
            end
            {lane_ok_valid, sb_ack, link_err, retrain_req} = 4'd0;
            chk_cnt++;
            if (state !== 4'd2) $display("FAIL deg_pattern[%0d]: got %0d want 2", t, state);
            else pass_cnt++;
            lane_ok = v; lane_ok_valid = 1'b1;
            step(1);
            lane_ok_valid = 1'b0;
            ref_resolve(v, em, ew, eok);
            if (eok) begin
                exp_st = 3; restart = 1'b1;
            end else begin
                attempts++;
                exp_st = (attempts >= 3) ? 6 : 1;
                if (attempts >= 3) restart = 1'b1;
            end
            chk_cnt++;
            if ({state, active_lanes, width_code, train_fail} !== {4'(exp_st), em, ew, 1'(exp_st == 6)})
                $display("FAIL deg_resolve[%0d] v=%h: got st=%0d m=%h w=%0d tf=%0d want st=%0d m=%h w=%0d",
                         t, v, state, active_lanes, width_code, train_fail, exp_st, em, ew);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout_fail();
        start = 1'b0; step(1);
        start = 1'b1; step(1);
        for (int a = 0; a < 3; a++) begin
            step(8);
            chk_cnt++;
            if (state !== 4'd2) $display("FAIL to_pattern[%0d]: got %0d want 2", a, state);
            else pass_cnt++;
            step(31);
            chk_cnt++;
            if (state !== 4'd2) $display("FAIL to_hold[%0d]: got %0d want 2", a, state);
            else pass_cnt++;
            step(1);
            chk_cnt++;
            if ({state, train_fail} !== {(a == 2) ? 4'd6 : 4'd1, 1'(a == 2)})
                $display("FAIL to_expire[%0d]: got st=%0d tf=%0d want st=%0d", a, state, train_fail, (a == 2) ? 6 : 1);
            else pass_cnt++;
        end
        step(5);
        chk_cnt++;
        if ({state, train_fail} !== {4'd6, 1'b1}) $display("FAIL fail_hold: got st=%0d tf=%0d want 6 1", state, train_fail);
        else pass_cnt++;
        start = 1'b0;
        step(1);
        chk_cnt++;
        if ({state, train_fail} !== {4'd0, 1'b0}) $display("FAIL fail_clear: got st=%0d tf=%0d want 0 0", state, train_fail);
        else pass_cnt++;
    endtask

    task automatic test_ties();
        start = 1'b1; step(1);
        step(8); step(31);
        lane_ok = 16'hFFFF; lane_ok_valid = 1'b1;
        step(1);
        lane_ok_valid = 1'b0;
        chk_cnt++;
        if (state !== 4'd3) $display("FAIL tie_pattern: got %0d want 3", state);
        else pass_cnt++;
        step(31);
        sb_ack = 1'b1;
        step(1);
        sb_ack = 1'b0;
        chk_cnt++;
        if ({state, link_up} !== {4'd4, 1'b1}) $display("FAIL tie_config: got st=%0d up=%0d want 4 1", state, link_up);
        else pass_cnt++;
        start = 1'b0; step(1);
        start = 1'b1; step(1);
        step(8);
        lane_ok_valid = 1'b1;
        step(1);
        lane_ok_valid = 1'b0;
        step(31);
        chk_cnt++;
        if (state !== 4'd3) $display("FAIL cfg_wait: got %0d want 3", state);
        else pass_cnt++;
        step(1);
        chk_cnt++;
        if ({state, sb_req, active_lanes, width_code} !== {4'd1, 1'b0, 16'h0000, 2'd0})
            $display("FAIL cfg_timeout: got st=%0d req=%0d m=%h w=%0d want 1 0 0000 0", state, sb_req, active_lanes, width_code);
        else pass_cnt++;
    endtask

    task automatic test_retrain();
        logic [1:0] c;
        for (int n = 0; n < 300; n++) begin
            step(8);
            lane_ok = 16'hFFFF; lane_ok_valid = 1'b1;
            step(1);
            lane_ok_valid = 1'b0; sb_ack = 1'b1;
            step(1);
            sb_ack = 1'b0;
            step($urandom_range(0, 3));
            if (n < 3) begin
                chk_cnt++;
                if (state !== 4'd4) $display("FAIL rt_active[%0d]: got %0d want 4", n, state);
                else pass_cnt++;
            end
            c = (n == 0) ? 2'd3 : 2'($urandom_range(1, 3));
            link_err = c[0]; retrain_req = c[1];
            step(1);
            link_err = 1'b0; retrain_req = 1'b0;
            m_rc = (m_rc < 255) ? m_rc + 1 : 255;
            if (n < 3 || n == 299) begin
                chk_cnt++;
                if ({state, link_up, retrain_cnt} !== {4'd5, 1'b0, 8'(m_rc)})
                    $display("FAIL rt_enter[%0d]: got st=%0d up=%0d cnt=%0d want 5 0 %0d", n, state, link_up, retrain_cnt, m_rc);
                else pass_cnt++;
            end
            step(1);
            if (n < 3) begin
                chk_cnt++;
                if (state !== 4'd1) $display("FAIL rt_detect[%0d]: got %0d want 1", n, state);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_async_reset();
        step(8);
        lane_ok = 16'hFFFF; lane_ok_valid = 1'b1;
        step(1);
        lane_ok_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_rc = 0;
        chk_cnt++;
        if ({state, link_up, sb_req, width_code, train_fail} !== 9'd0)
            $display("FAIL async_ctl: got %h want 0", {state, link_up, sb_req, width_code, train_fail});
        else pass_cnt++;
        chk_cnt++;
        if ({active_lanes, retrain_cnt} !== {16'h0000, 8'(m_rc)})
            $display("FAIL async_data: got m=%h cnt=%0d want 0 0", active_lanes, retrain_cnt);
        else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        step(1);
        chk_cnt++;
        if (state !== 4'd1) $display("FAIL post_reset: got %0d want 1", state);
        else pass_cnt++;
    endtask

    task automatic test_start_drop();
        step(8);
        lane_ok = 16'h00FF; lane_ok_valid = 1'b1;
        step(1);
        lane_ok_valid = 1'b0; sb_ack = 1'b1;
        step(1);
        sb_ack = 1'b0;
        chk_cnt++;
        if ({state, width_code} !== {4'd4, 2'd2}) $display("FAIL drop_active: got st=%0d w=%0d want 4 2", state, width_code);
        else pass_cnt++;
        start = 1'b0; link_err = 1'b1;
        step(1);
        link_err = 1'b0;
        chk_cnt++;
        if ({state, link_up, retrain_cnt} !== {4'd0, 1'b0, 8'(m_rc)})
            $display("FAIL drop_reset: got st=%0d up=%0d cnt=%0d want 0 0 %0d", state, link_up, retrain_cnt, m_rc);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full_width();
        test_degrade();
        test_timeout_fail();
        test_ties();
        test_retrain();
        test_async_reset();
        test_start_drop();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
